// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: captures tick and compare events from the system
// counter and presents one prioritised request to the core with an ack/done handshake.
module timer_irq_ctrl #(
    parameter int   OVR_W     = 8,
    parameter logic TICK_PRIO = 1'b1
) (
    input  logic        proc_clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        tick_en,
    input  logic        cmp_match,
    input  logic        irq_ack,
    input  logic        irq_done,
    input  logic [1:0]  reg_sel,
    input  logic        reg_wr_en,
    input  logic [31:0] reg_wrdata,
    output logic [31:0] reg_rddata,
    output logic        irq_req,
    output logic        irq_cause,
    output logic        irq_active
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PEND = 2'b01,
        SERV = 2'b10
    } state_e;

    localparam logic [OVR_W-1:0] OVR_MAX = '1;

    state_e           state_q, state_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             tickPend_q, tickPend_d;
    logic             cmpPend_q, cmpPend_d;
    logic [OVR_W-1:0] overrun_q, overrun_d;
    logic             cmp_q;
    logic             cause_q, cause_d;
    logic [31:0]      rddata_q, rddata_d;

    logic wrCtrl, wrStat, wrOvr;
    logic tickEl, cmpEl, anyEl, winTick;
    logic cmpEvt, ackTake;
    logic unusedWrBits;

    assign unusedWrBits = ^reg_wrdata[31:3];

    assign wrCtrl  = reg_wr_en & (reg_sel == 2'b00);
    assign wrStat  = reg_wr_en & (reg_sel == 2'b01);
    assign wrOvr   = reg_wr_en & (reg_sel == 2'b10);
    assign tickEl  = tickPend_q & ctrl_q[0];
    assign cmpEl   = cmpPend_q & ctrl_q[1];
    assign anyEl   = tickEl | cmpEl;
    assign winTick = tickEl & (ctrl_q[2] | ~cmpEl);
    assign cmpEvt  = cmp_match & ~cmp_q;
    // An ack only counts when the FSM actually moves PEND -> SERV this edge.
    assign ackTake = (state_q == PEND) & ~freeze & irq_ack & anyEl;

    always_ff @(posedge proc_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!freeze) begin
            case (state_q)
                IDLE: if (anyEl) state_d = PEND;
                PEND: begin
                    if (!anyEl) begin
                        state_d = IDLE;
                    end else if (irq_ack) begin
                        state_d = SERV;
                    end
                end
                SERV: if (irq_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Cause follows the live winner while requesting, otherwise the value latched at ack.
    always_comb begin
        irq_req    = (state_q == PEND);
        irq_active = (state_q == SERV);
        irq_cause  = (state_q == PEND) ? winTick : cause_q;
    end

    // New events take precedence over both software clears and ack clears.
    always_comb begin
        tickPend_d = tick_en
                   | (tickPend_q & ~(wrStat & reg_wrdata[0]) & ~(ackTake & winTick));
        cmpPend_d  = cmpEvt
                   | (cmpPend_q & ~(wrStat & reg_wrdata[1]) & ~(ackTake & ~winTick));
        ctrl_d     = wrCtrl ? reg_wrdata[2:0] : ctrl_q;
        cause_d    = ackTake ? winTick : cause_q;
        overrun_d  = overrun_q;
        if (wrOvr) begin
            overrun_d = '0;
        end else if (tick_en && tickPend_q && (overrun_q != OVR_MAX)) begin
            overrun_d = overrun_q + OVR_W'(1);
        end
    end

    always_comb begin
        case (reg_sel)
            2'b00:   rddata_d = {29'b0, ctrl_q};
            2'b01:   rddata_d = {26'b0, state_q, 2'b00, cmpPend_q, tickPend_q};
            2'b10:   rddata_d = 32'(overrun_q);
            default: rddata_d = 32'b0;
        endcase
    end

    always_ff @(posedge proc_clk) begin
        if (rst) begin
            ctrl_q     <= {TICK_PRIO, 2'b00};
            tickPend_q <= 1'b0;
            cmpPend_q  <= 1'b0;
            overrun_q  <= '0;
            cmp_q      <= 1'b0;
            cause_q    <= 1'b0;
            rddata_q   <= 32'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            tickPend_q <= tickPend_d;
            cmpPend_q  <= cmpPend_d;
            overrun_q  <= overrun_d;
            cmp_q      <= cmp_match;
            cause_q    <= cause_d;
            rddata_q   <= rddata_d;
        end
    end

    assign reg_rddata = rddata_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: hand-derived vector table, directed corner sequences
// and random stimulus, all checked against a behavioural model of the controller.
module tb_timer_irq_ctrl;

    localparam int   OVR_W     = 8;
    localparam logic TICK_PRIO = 1'b1;
    localparam int   OVR_MAX   = (1 << OVR_W) - 1;

    typedef struct {
        logic        rst, freeze, tick, cmp, ack, done, wr;
        logic [1:0]  sel;
        logic [31:0] wd;
        logic        eReq, eCause, eActive;
        logic [31:0] eRd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0, freeze = 1'b0, tickEn = 1'b0, cmpMatch = 1'b0;
    logic        irqAck = 1'b0, irqDone = 1'b0, regWrEn = 1'b0;
    logic [1:0]  regSel = 2'b00;
    logic [31:0] regWrdata = 32'b0;
    logic [31:0] regRddata;
    logic        irqReq, irqCause, irqActive;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: pending flags, a phase (0 idle, 1 requesting, 2 serving).
    logic        mTickPend, mCmpPend, mCmpPrev, mCause;
    logic [2:0]  mCtrl;
    int          mOvr, mPhase;
    logic [31:0] mRd;

    vec_t tbl[16];

    always #5 clk = ~clk;

    timer_irq_ctrl #(.OVR_W(OVR_W), .TICK_PRIO(TICK_PRIO)) dut (
        .proc_clk  (clk),
        .rst       (rst),
        .freeze    (freeze),
        .tick_en   (tickEn),
        .cmp_match (cmpMatch),
        .irq_ack   (irqAck),
        .irq_done  (irqDone),
        .reg_sel   (regSel),
        .reg_wr_en (regWrEn),
        .reg_wrdata(regWrdata),
        .reg_rddata(regRddata),
        .irq_req   (irqReq),
        .irq_cause (irqCause),
        .irq_active(irqActive)
    );

    function automatic vec_t mkRow(input logic [6:0] ctl, input logic [1:0] sel,
                                   input logic [31:0] wd, input logic [2:0] exp,
                                   input logic [31:0] eRd);
        vec_t v;
        {v.rst, v.freeze, v.tick, v.cmp, v.ack, v.done, v.wr} = ctl;
        v.sel = sel;
        v.wd  = wd;
        {v.eReq, v.eCause, v.eActive} = exp;
        v.eRd = eRd;
        return v;
    endfunction

    function automatic vec_t mkVec(input logic [1:0] sel);
        return mkRow(7'b0, sel, 32'b0, 3'b0, 32'b0);
    endfunction

    function automatic logic modelWinnerTick();
        logic t, c;
        t = mTickPend && mCtrl[0];
        c = mCmpPend && mCtrl[1];
        return t && (mCtrl[2] || !c);
    endfunction

    task automatic modelStep(input vec_t v);
        logic tEl, cEl, win, taken, clrT, clrC;
        if (v.rst) begin
            mTickPend = 0; mCmpPend = 0; mCmpPrev = 0; mCause = 0;
            mCtrl = {TICK_PRIO, 2'b00}; mOvr = 0; mPhase = 0; mRd = 0;
            return;
        end
        tEl = mTickPend && mCtrl[0];
        cEl = mCmpPend && mCtrl[1];
        win = modelWinnerTick();
        case (v.sel)
            2'd0:    mRd = {29'b0, mCtrl};
            2'd1:    mRd = 32'(mTickPend) + 2 * 32'(mCmpPend) + 16 * mPhase;
            2'd2:    mRd = mOvr;
            default: mRd = 0;
        endcase
        taken = (mPhase == 1) && !v.freeze && v.ack && (tEl || cEl);
        clrT  = v.wr && v.sel == 2'd1 && v.wd[0];
        clrC  = v.wr && v.sel == 2'd1 && v.wd[1];
        if (v.wr && v.sel == 2'd2) mOvr = 0;
        else if (v.tick && mTickPend && mOvr < OVR_MAX) mOvr = mOvr + 1;
        mTickPend = v.tick || (mTickPend && !clrT && !(taken && win));
        mCmpPend  = (v.cmp && !mCmpPrev) || (mCmpPend && !clrC && !(taken && !win));
        mCmpPrev  = v.cmp;
        if (v.wr && v.sel == 2'd0) mCtrl = v.wd[2:0];
        if (taken) mCause = win;
        if (!v.freeze) begin
            if (mPhase == 0 && (tEl || cEl)) mPhase = 1;
            else if (mPhase == 1 && !(tEl || cEl)) mPhase = 0;
            else if (mPhase == 1 && v.ack) mPhase = 2;
            else if (mPhase == 2 && v.done) mPhase = 0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst = v.rst; freeze = v.freeze; tickEn = v.tick; cmpMatch = v.cmp;
        irqAck = v.ack; irqDone = v.done; regWrEn = v.wr; regSel = v.sel; regWrdata = v.wd;
        @(posedge clk);
        modelStep(v);
        #1;
        checkOutput("model_rddata", regRddata, mRd);
        checkOutput("model_irq_req", 32'(irqReq), 32'(mPhase == 1));
        checkOutput("model_irq_active", 32'(irqActive), 32'(mPhase == 2));
        checkOutput("model_irq_cause", 32'(irqCause),
                    32'((mPhase == 1) ? modelWinnerTick() : mCause));
    endtask

    task automatic resetAndCtrl(input logic [31:0] ctrl);
        vec_t v;
        applyStimulus(mkRow(7'b1000000, 2'd0, 32'b0, 3'b0, 32'b0));
        v = mkVec(2'd0); v.wr = 1; v.wd = ctrl;
        applyStimulus(v);
    endtask

    initial begin
        vec_t v;
        int   reqCount;
        logic prevReq;

        tbl[0]  = mkRow(7'b1000000, 2'd1, 32'h0, 3'b000, 32'h00);
        tbl[1]  = mkRow(7'b0000001, 2'd0, 32'h1, 3'b000, 32'h04);
        tbl[2]  = mkRow(7'b0010000, 2'd1, 32'h0, 3'b000, 32'h00);
        tbl[3]  = mkRow(7'b0000000, 2'd1, 32'h0, 3'b110, 32'h01);
        tbl[4]  = mkRow(7'b0010001, 2'd1, 32'h1, 3'b110, 32'h11);
        tbl[5]  = mkRow(7'b0000001, 2'd1, 32'h1, 3'b100, 32'h11);
        tbl[6]  = mkRow(7'b0000100, 2'd1, 32'h0, 3'b000, 32'h10);
        tbl[7]  = mkRow(7'b0000000, 2'd2, 32'h0, 3'b000, 32'h01);
        tbl[8]  = mkRow(7'b0000001, 2'd2, 32'h0, 3'b000, 32'h01);
        tbl[9]  = mkRow(7'b0000000, 2'd2, 32'h0, 3'b000, 32'h00);
        tbl[10] = mkRow(7'b0010000, 2'd1, 32'h0, 3'b000, 32'h00);
        tbl[11] = mkRow(7'b0000000, 2'd1, 32'h0, 3'b110, 32'h01);
        tbl[12] = mkRow(7'b0000100, 2'd1, 32'h0, 3'b011, 32'h11);
        tbl[13] = mkRow(7'b0000000, 2'd1, 32'h0, 3'b011, 32'h20);
        tbl[14] = mkRow(7'b0000010, 2'd1, 32'h0, 3'b010, 32'h20);
        tbl[15] = mkRow(7'b0000000, 2'd1, 32'h0, 3'b010, 32'h00);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("row%0d_req", i), 32'(irqReq), 32'(tbl[i].eReq));
            checkOutput($sformatf("row%0d_cause", i), 32'(irqCause), 32'(tbl[i].eCause));
            checkOutput($sformatf("row%0d_active", i), 32'(irqActive), 32'(tbl[i].eActive));
            checkOutput($sformatf("row%0d_rddata", i), regRddata, tbl[i].eRd);
        end

        // A held compare level yields one request; a fresh rising edge yields another.
        resetAndCtrl(32'h2);
        reqCount = 0;
        prevReq  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            v = mkVec(2'd1); v.cmp = 1; v.ack = irqReq; v.done = irqActive;
            applyStimulus(v);
            if (irqReq && !prevReq) reqCount++;
            prevReq = irqReq;
        end
        checkOutput("cmp_held_req_count", reqCount, 1);
        for (int i = 0; i < 2; i++) applyStimulus(mkVec(2'd1));
        for (int i = 0; i < 2; i++) begin
            v = mkVec(2'd1); v.cmp = 1;
            applyStimulus(v);
        end
        checkOutput("cmp_second_req", 32'(irqReq), 32'd1);
        v = mkVec(2'd1); v.cmp = 1; v.ack = 1; applyStimulus(v);
        v = mkVec(2'd1); v.cmp = 1; v.done = 1; applyStimulus(v);

        // Simultaneous sources: priority bit picks the first served, the other follows.
        for (int pass = 0; pass < 2; pass++) begin
            resetAndCtrl(pass == 0 ? 32'h7 : 32'h3);
            v = mkVec(2'd1); v.tick = 1; v.cmp = 1; applyStimulus(v);
            applyStimulus(mkVec(2'd1));
            checkOutput($sformatf("prio%0d_first_cause", pass), 32'(irqCause), pass == 0 ? 1 : 0);
            v = mkVec(2'd1); v.ack = 1;  applyStimulus(v);
            v = mkVec(2'd1); v.done = 1; applyStimulus(v);
            applyStimulus(mkVec(2'd1));
            checkOutput($sformatf("prio%0d_second_req", pass), 32'(irqReq), 32'd1);
            checkOutput($sformatf("prio%0d_second_cause", pass), 32'(irqCause), pass == 0 ? 0 : 1);
            v = mkVec(2'd1); v.ack = 1;  applyStimulus(v);
            v = mkVec(2'd1); v.done = 1; applyStimulus(v);
        end

        // Disabled tick floods saturate the overrun counter without requesting.
        resetAndCtrl(32'h0);
        reqCount = 0;
        for (int i = 0; i < 300; i++) begin
            v = mkVec(2'd2); v.tick = 1;
            applyStimulus(v);
            if (irqReq) reqCount++;
        end
        checkOutput("flood_req_count", reqCount, 0);
        applyStimulus(mkVec(2'd2));
        checkOutput("overrun_saturated", regRddata, OVR_MAX);
        v = mkVec(2'd2); v.wr = 1; applyStimulus(v);
        applyStimulus(mkVec(2'd2));
        checkOutput("overrun_cleared", regRddata, 32'd0);
        applyStimulus(mkVec(2'd1));
        checkOutput("flood_tick_pend", regRddata, 32'h1);

        // Freeze holds IDLE with the event captured; reset from SERV clears everything.
        resetAndCtrl(32'h1);
        v = mkVec(2'd1); v.tick = 1; applyStimulus(v);
        for (int i = 0; i < 4; i++) begin
            v = mkVec(2'd1); v.freeze = 1;
            applyStimulus(v);
        end
        checkOutput("freeze_no_req", 32'(irqReq), 32'd0);
        checkOutput("freeze_status", regRddata, 32'h1);
        applyStimulus(mkVec(2'd1));
        checkOutput("unfreeze_req", 32'(irqReq), 32'd1);
        v = mkVec(2'd1); v.ack = 1; applyStimulus(v);
        checkOutput("serv_active", 32'(irqActive), 32'd1);
        v = mkVec(2'd1); v.rst = 1; v.tick = 1; applyStimulus(v);
        checkOutput("rst_req", 32'(irqReq), 32'd0);
        checkOutput("rst_active", 32'(irqActive), 32'd0);
        checkOutput("rst_cause", 32'(irqCause), 32'd0);
        checkOutput("rst_rddata", regRddata, 32'd0);
        applyStimulus(mkVec(2'd1));
        checkOutput("rst_event_lost", regRddata, 32'd0);

        // Random traffic against the model.
        resetAndCtrl(32'h3);
        for (int i = 0; i < 3000; i++) begin
            v = mkVec(2'($urandom_range(0, 3)));
            v.rst    = ($urandom_range(0, 199) == 0);
            v.freeze = ($urandom_range(0, 4) == 0);
            v.tick   = ($urandom_range(0, 3) == 0);
            v.cmp    = ($urandom_range(0, 5) == 0) ? ~cmpMatch : cmpMatch;
            v.ack    = ($urandom_range(0, 2) == 0);
            v.done   = ($urandom_range(0, 3) == 0);
            v.wr     = ($urandom_range(0, 7) == 0);
            v.wd     = $urandom;
            applyStimulus(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
Timer interrupt controller directly downstream of the system counter block. It consumes two signals from the system counter:
- the periodic tick pulse (tick_en);
- the time-versus-timecmp compare level (cmp_match).

It turns these into a single prioritised interrupt request to the core, with an acknowledge/complete handshake. It also has a small CSR-style register window for enables, pending status and a tick overrun count.

Parameters:
OVR_W, 8, width of saturating tick-overrun counter (1..16)
TICK_PRIO, 1, reset value of ctrl[2]; 1 = tick wins over compare when both pending

Ports:
proc_clk  in  1  processor clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
freeze  in  1  pipeline freeze; stalls FSM transitions only
tick_en  in  1  one-cycle tick pulse from system counter
cmp_match  in  1  level, high while time >= timecmp
irq_ack  in  1  core accepts the interrupt (one-cycle pulse)
irq_done  in  1  core finished the handler (mret, one-cycle pulse)
reg_sel  in  2  00 ctrl, 01 status, 10 overrun, 11 reserved
reg_wr_en  in  1  register write strobe
reg_wrdata  in  32  write data
reg_rddata  out  32  registered read data for reg_sel
irq_req  out  1  interrupt request to core
irq_cause  out  1  0 = compare, 1 = tick; valid while irq_req or irq_active
irq_active  out  1  handler in service

Behaviour:
- One clock, proc_clk; rst synchronous active-high.
- Reset values:
  - state IDLE;
  - ctrl = {29'b0, TICK_PRIO, 2'b00}, i.e. both enables off;
  - tick_pend = cmp_pend = 0; overrun = 0; cmp_q = 0;
  - reg_rddata = 0, irq_req = 0, irq_cause = 0, irq_active = 0.
- Registers:
  - ctrl[0] tick_ie, ctrl[1] cmp_ie, ctrl[2] prio_tick. Written whole; other bits read 0.
  - status: bit0 tick_pend, bit1 cmp_pend, bits5:4 FSM state encoding (IDLE=00, PEND=01, SERV=10). Writes are write-1-to-clear on bits 1:0 only.
  - overrun: zero-extended to 32 bits. Any write clears it to 0.
  - reg_sel 11: reads 0, writes ignored.
  - reg_rddata updates every cycle from the current reg_sel, so read latency is 1 cycle. It shows pre-write values in the cycle of a write.
- Event capture is independent of freeze and of the enables:
  - Tick event = tick_en.
  - Compare event = cmp_match & ~cmp_q, where cmp_q is cmp_match registered. This is a rising edge, so a held-high cmp_match produces exactly one event.
  - An event sets its pending bit on the next edge.
  - Same-cycle set and W1C on one bit: set wins.
  - A tick event while tick_pend is already 1 increments overrun, saturating at 2^OVR_W-1. The same-cycle overrun write clear wins over the increment.
- Eligibility: tick_el = tick_pend & tick_ie; cmp_el = cmp_pend & cmp_ie.
- FSM (transitions only when freeze = 0; when freeze = 1 the state holds):
  - IDLE -> PEND when tick_el | cmp_el.
  - PEND:
    - irq_req = 1.
    - irq_cause = winner: tick if tick_el & (prio_tick | ~cmp_el), else compare. Recomputed every cycle.
    - PEND -> IDLE if no source is eligible (software cleared it or disabled it). irq_ack in that same cycle is ignored.
    - irq_ack -> SERV. The winner's pending bit clears and irq_cause is frozen. The same-cycle new event for the winner still sets it (set wins).
  - SERV:
    - irq_active = 1, irq_req = 0.
    - irq_done -> IDLE. If a source is still eligible, the FSM re-enters PEND on the following cycle.
  - irq_ack outside PEND and irq_done outside SERV are ignored.
- Outputs irq_req and irq_active are decoded from the state register (no extra latency).
- Latency:
  - tick_en in cycle N gives tick_pend at N+1 and irq_req at N+2.
  - cmp_match rising in cycle N gives irq_req at N+2.
- rst mid-operation, in any state, returns everything to reset values on that edge. A pending event in the same cycle is lost.

Test Plan:
1. Reset, ctrl=0x1, single tick_en pulse at cycle 10 -> tick_pend=1 at 11, irq_req=1 and irq_cause=1 at 12; irq_ack at 14 -> irq_active=1 and tick_pend=0 at 15; irq_done at 20 -> IDLE at 21, irq_req stays 0.
2. ctrl=0x2, cmp_match held high 50 cycles -> exactly one compare event; after ack/done no second irq_req; drop then raise cmp_match -> second request.
3. ctrl=0x7, tick_en and cmp_match rise in the same cycle -> irq_cause=1. Ack, then done -> re-enters PEND with irq_cause=0. Repeat with ctrl=0x3 -> compare served first.
4. ctrl=0x0, 300 tick pulses with OVR_W=8 -> tick_pend=1, overrun reads 255 (saturated), irq_req never asserted. Write overrun -> reads 0 next cycle.
5. In PEND, W1C status=0x1 in the same cycle as tick_en -> tick_pend stays 1. Next cycle W1C alone -> PEND->IDLE, irq_req drops, and irq_ack in that cycle is ignored.
6. freeze=1 while tick_pend eligible in IDLE -> state holds IDLE and pend stays captured; freeze=0 -> irq_req 1 cycle later. Assert rst while in SERV -> all outputs 0 next cycle.
